// File: rtl/receive_packet_seg_if.sv
// Packet word bus between the deframer (master) and receive_packet_seg (slave).
// One transfer moves a whole framed packet: 5 header words followed by the payload.
interface receive_packet_seg_if #(
    parameter int DATA_WORDS = 4
);
    logic                            pkt_valid;
    logic                            pkt_ready;
    logic [32*(5+DATA_WORDS)-1:0]    packet;

    modport master (output pkt_valid, output packet, input pkt_ready);
    modport slave  (input pkt_valid, input packet, output pkt_ready);
endinterface

// File: rtl/receive_packet_seg.sv
// Lasernet packet receiver: checksum check, sequence tracking and message assembly.
// Define REORDER_EN to store out-of-order segments and skip next_sn past filled gaps.
module receive_packet_seg #(
    parameter int         DATA_WORDS   = 4,
    parameter int         NUM_SEGMENTS = 5,
    parameter logic [7:0] BLANK_BYTE   = 8'h20
) (
    input  logic                                  clk,
    input  logic                                  reset,
    receive_packet_seg_if.slave                   pkt_if,
    input  logic [31:0]                           ISN,
    output logic [31:0]                           seq,
    output logic [31:0]                           ack,
    output logic [8:0]                            flags,
    output logic [32*DATA_WORDS*NUM_SEGMENTS-1:0] message,
    output logic [NUM_SEGMENTS-1:0]               seg_valid,
    output logic [31:0]                           next_sn,
    output logic                                  msg_complete,
    output logic [15:0]                           bad_count,
    output logic [15:0]                           dup_count
);

    localparam int PKT_BITS  = 32 * (5 + DATA_WORDS);
    localparam int SEG_BITS  = 32 * DATA_WORDS;
    localparam int MSG_BITS  = SEG_BITS * NUM_SEGMENTS;
    localparam int HALFWORDS = 2 * (5 + DATA_WORDS);
    localparam int W2_LSB    = PKT_BITS - 64;
    localparam int W3_LSB    = PKT_BITS - 96;
    localparam int W4_LSB    = PKT_BITS - 128;
    localparam logic [31:0] LAST_SN = 32'(NUM_SEGMENTS);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        CHECK
    } state_t;

    state_t                state_q, state_d;
    logic [PKT_BITS-1:0]   pkt_q, pkt_d;
    logic                  pkt_ready_q, pkt_ready_d;
    logic [31:0]           seq_q, seq_d;
    logic [31:0]           ack_q, ack_d;
    logic [8:0]            flags_q, flags_d;
    logic [MSG_BITS-1:0]   message_q, message_d;
    logic [NUM_SEGMENTS-1:0] seg_valid_q, seg_valid_d;
    logic [31:0]           next_sn_q, next_sn_d;
    logic [15:0]           bad_count_q, bad_count_d;
    logic [15:0]           dup_count_q, dup_count_d;

    logic [31:0] word2, word3, sn;
    logic [8:0]  word4_flags;
    logic [15:0] csum;
    logic        csum_good, in_range, in_order, sn_is_old, write_seg;

    assign word2       = pkt_q[W2_LSB +: 32];
    assign word3       = pkt_q[W3_LSB +: 32];
    assign word4_flags = pkt_q[W4_LSB + 16 +: 9];

    assign sn        = word2 - ISN;
    assign in_range  = (sn != 32'd0) && (sn <= LAST_SN);
    assign in_order  = in_range && (sn == next_sn_q);
    assign sn_is_old = (sn != 32'd0) && (sn < next_sn_q);

    // Ones-complement sum over every halfword; a correct packet folds to 16'hFFFF.
    always_comb begin
        logic [31:0] sum;
        logic [31:0] fold1;
        logic [31:0] fold2;
        sum = 32'd0;
        for (int i = 0; i < HALFWORDS; i++) begin
            sum = sum + {16'h0, pkt_q[i*16 +: 16]};
        end
        fold1     = {16'h0, sum[15:0]} + {16'h0, sum[31:16]};
        fold2     = {16'h0, fold1[15:0]} + {16'h0, fold1[31:16]};
        csum      = ~fold2[15:0];
        csum_good = (csum == 16'h0);
    end

`ifdef REORDER_EN
    logic        sn_taken;
    logic [31:0] jump_sn;

    // Lowest empty slot above the incoming SN becomes the new next_sn.
    always_comb begin
        sn_taken = 1'b0;
        jump_sn  = LAST_SN + 32'd1;
        for (int k = 1; k <= NUM_SEGMENTS; k++) begin
            if (sn == 32'(k)) begin
                sn_taken = seg_valid_q[k-1];
            end
        end
        for (int k = NUM_SEGMENTS; k >= 1; k--) begin
            if ((32'(k) > sn) && !seg_valid_q[k-1]) begin
                jump_sn = 32'(k);
            end
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        pkt_d       = pkt_q;
        seq_d       = seq_q;
        ack_d       = ack_q;
        flags_d     = flags_q;
        message_d   = message_q;
        seg_valid_d = seg_valid_q;
        next_sn_d   = next_sn_q;
        bad_count_d = bad_count_q;
        dup_count_d = dup_count_q;
        write_seg   = 1'b0;

        case (state_q)
            IDLE: begin
                if (pkt_if.pkt_valid && pkt_ready_q) begin
                    pkt_d   = pkt_if.packet;
                    state_d = CHECK;
                end
            end
            CAPTURE: begin
                state_d = CHECK;
            end
            CHECK: begin
                state_d = IDLE;
                if (!csum_good) begin
                    if (bad_count_q != 16'hFFFF) begin
                        bad_count_d = bad_count_q + 16'd1;
                    end
                end else begin
                    ack_d   = word3;
                    flags_d = word4_flags;
                    if (in_order) begin
                        write_seg = 1'b1;
`ifdef REORDER_EN
                        next_sn_d = jump_sn;
                        seq_d     = ISN + jump_sn - 32'd1;
`else
                        next_sn_d = next_sn_q + 32'd1;
                        seq_d     = word2;
`endif
                    end else if (sn_is_old
`ifdef REORDER_EN
                                 || (in_range && sn_taken)
`endif
                                 ) begin
                        if (dup_count_q != 16'hFFFF) begin
                            dup_count_d = dup_count_q + 16'd1;
                        end
                    end
`ifdef REORDER_EN
                    else if (in_range && (sn > next_sn_q)) begin
                        write_seg = 1'b1;
                    end
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        for (int k = 1; k <= NUM_SEGMENTS; k++) begin
            if (write_seg && (sn == 32'(k))) begin
                message_d[(k-1)*SEG_BITS +: SEG_BITS] = pkt_q[SEG_BITS-1:0];
                seg_valid_d[k-1] = 1'b1;
            end
        end

        pkt_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            pkt_q       <= '0;
            pkt_ready_q <= 1'b0;
            seq_q       <= 32'd0;
            ack_q       <= 32'd0;
            flags_q     <= 9'd0;
            message_q   <= {(MSG_BITS/8){BLANK_BYTE}};
            seg_valid_q <= '0;
            next_sn_q   <= 32'd1;
            bad_count_q <= 16'd0;
            dup_count_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            pkt_q       <= pkt_d;
            pkt_ready_q <= pkt_ready_d;
            seq_q       <= seq_d;
            ack_q       <= ack_d;
            flags_q     <= flags_d;
            message_q   <= message_d;
            seg_valid_q <= seg_valid_d;
            next_sn_q   <= next_sn_d;
            bad_count_q <= bad_count_d;
            dup_count_q <= dup_count_d;
        end
    end

    assign pkt_if.pkt_ready = pkt_ready_q;
    assign seq              = seq_q;
    assign ack              = ack_q;
    assign flags            = flags_q;
    assign message          = message_q;
    assign seg_valid        = seg_valid_q;
    assign next_sn          = next_sn_q;
    assign msg_complete     = (next_sn_q > LAST_SN);
    assign bad_count        = bad_count_q;
    assign dup_count        = dup_count_q;

endmodule
